// File: rtl/mdu_ctrl.sv
// HI/LO owner for the EX stage: fixed-latency multiply/divide sequencer with
// decode-stage hazard stall and flush-gated start.
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        req,
   input  logic        md_use,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6,
      OP_RSVD  = 3'd7
   } op_e;

   typedef enum logic {IDLE, BUSY} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   hi_q, hi_d, lo_q, lo_d;
   logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
   logic          dz_q, dz_d;

   logic          start_eff;
   logic [63:0]   prod_s, prod_u;
   logic          signed_div, q_neg, r_neg;
   logic [31:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

   assign busy      = (state_q == BUSY);
   assign start_eff = start & ~req & ~busy & (op != OP_NONE) & (op != OP_RSVD);
   assign stall     = md_use & (busy | start_eff);
   assign hi        = hi_q;
   assign lo        = lo_q;

   // Sign-extending to 64 bits first makes the low 64 bits of an unsigned
   // multiply equal to the two's-complement signed product.
   assign prod_s = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
   assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};

   // Signed divide on magnitudes: quotient truncates toward zero, remainder
   // follows the dividend, and 0x80000000 / -1 wraps back to 0x80000000.
   assign signed_div = (op == OP_DIV);
   assign a_mag      = (signed_div & rs_data[31]) ? 32'd0 - rs_data : rs_data;
   assign b_mag      = (signed_div & rt_data[31]) ? 32'd0 - rt_data : rt_data;
   assign b_safe     = (rt_data == 32'd0) ? 32'd1 : b_mag;
   assign q_mag      = a_mag / b_safe;
   assign r_mag      = a_mag % b_safe;
   assign q_neg      = signed_div & (rs_data[31] ^ rt_data[31]);
   assign r_neg      = signed_div & rs_data[31];
   assign quot       = q_neg ? 32'd0 - q_mag : q_mag;
   assign rem        = r_neg ? 32'd0 - r_mag : r_mag;

   // NOTE: every output of this block is given its hold value first, so no
   // path through the case statements can leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      dz_d      = dz_q;
      case (state_q)
         IDLE: begin
            if (start_eff) begin
               case (op)
                  OP_MULT: begin
                     pend_hi_d = prod_s[63:32];
                     pend_lo_d = prod_s[31:0];
                     dz_d      = 1'b0;
                     cnt_d     = CW'(MULT_CYCLES);
                     state_d   = BUSY;
                  end
                  OP_MULTU: begin
                     pend_hi_d = prod_u[63:32];
                     pend_lo_d = prod_u[31:0];
                     dz_d      = 1'b0;
                     cnt_d     = CW'(MULT_CYCLES);
                     state_d   = BUSY;
                  end
                  OP_DIV, OP_DIVU: begin
                     pend_hi_d = rem;
                     pend_lo_d = quot;
                     dz_d      = (rt_data == 32'd0);
                     cnt_d     = CW'(DIV_CYCLES);
                     state_d   = BUSY;
                  end
                  OP_MTHI: hi_d = rs_data;
                  OP_MTLO: lo_d = rs_data;
                  default: ;
               endcase
            end
         end
         BUSY: begin
            if (cnt_q == CW'(1)) begin
               state_d = IDLE;
               cnt_d   = '0;
               if (!dz_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         dz_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         dz_q      <= dz_d;
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: expected HI/LO pairs are queued at issue and
// compared at commit, alongside busy length, stall and reset behaviour.
`timescale 1ns/1ps
module tb_mdu_ctrl;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_data, rt_data;
   logic        req, md_use;
   logic        busy, stall;
   logic [31:0] hi, lo;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fails  = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .rs_data(rs_data), .rt_data(rt_data), .req(req), .md_use(md_use),
      .busy(busy), .stall(stall), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, required finish before 200us");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pop_and_compare(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check({tag, "_hi"}, hi, e.hi);
         check({tag, "_lo"}, lo, e.lo);
         m_hi = e.hi;
         m_lo = e.lo;
      end
   endtask

   // Called at posedge+1; returns at posedge+1 of the first cycle busy is low,
   // so consecutive calls exercise back-to-back acceptance.
   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int n, input logic [31:0] eh,
                         input logic [31:0] el, input int stray_at, input int req_at);
      int cycles;
      check({tag, "_idle"}, 32'(busy), 32'd0);
      start = 1'b1; op = o; rs_data = a; rt_data = b; md_use = 1'b1;
      #1 check({tag, "_stall_start"}, 32'(stall), 32'd1);
      sb.push_back('{eh, el});
      @(posedge clk); #1;
      start = 1'b0; op = 3'd0; rs_data = '0; rt_data = '0;
      cycles = 0;
      while (busy === 1'b1 && cycles < 100) begin
         if (cycles == stray_at) begin
            $display("note: %s deliberate start while busy (protocol error)", tag);
            start = 1'b1; op = 3'd1; rs_data = 32'd7; rt_data = 32'd9;
         end
         if (cycles == req_at) req = 1'b1;
         #1;
         check({tag, "_stall_busy"}, 32'(stall), 32'd1);
         check({tag, "_hi_hold"}, hi, m_hi);
         @(posedge clk); #1;
         start = 1'b0; req = 1'b0; op = 3'd0; rs_data = '0; rt_data = '0;
         cycles++;
      end
      check({tag, "_busy_len"}, 32'(cycles), 32'(n));
      check({tag, "_stall_done"}, 32'(stall), 32'd0);
      pop_and_compare(tag);
      md_use = 1'b0;
   endtask

   task automatic run_mt(input string tag, input logic [2:0] o, input logic [31:0] v);
      start = 1'b1; op = o; rs_data = v; md_use = 1'b0;
      #1 check({tag, "_stall"}, 32'(stall), 32'd0);
      if (o == 3'd5) sb.push_back('{v, m_lo});
      else           sb.push_back('{m_hi, v});
      @(posedge clk); #1;
      start = 1'b0; op = 3'd0; rs_data = '0;
      check({tag, "_busy"}, 32'(busy), 32'd0);
      pop_and_compare(tag);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; op = 3'd0; rs_data = '0; rt_data = '0;
      req = 1'b0; md_use = 1'b0;
      #3;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1;

      run_op("mult",   3'd1, 32'hFFFFFFFD, 32'd5, MC, 32'hFFFFFFFF, 32'hFFFFFFF1, 1, -1);
      run_op("multu",  3'd2, 32'hFFFFFFFD, 32'd5, MC, 32'h00000004, 32'hFFFFFFF1, -1, -1);
      run_op("divu",   3'd4, 32'd100, 32'd7, DC, 32'd2, 32'd14, -1, -1);
      run_op("div_neg", 3'd3, 32'hFFFFFFF9, 32'd2, DC, 32'hFFFFFFFF, 32'hFFFFFFFD, -1, -1);
      run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, DC, 32'h0, 32'h80000000, -1, -1);

      run_mt("mthi", 3'd5, 32'h1234);
      run_mt("mtlo", 3'd6, 32'h5678);
      run_op("div_zero", 3'd3, 32'd55, 32'd0, DC, 32'h1234, 32'h5678, -1, -1);

      // start squashed by a concurrent flush
      start = 1'b1; op = 3'd1; rs_data = 32'd5; rt_data = 32'd5; req = 1'b1; md_use = 1'b1;
      #1 check("flush_stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      start = 1'b0; op = 3'd0; req = 1'b0;
      check("flush_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      check("flush_busy2", 32'(busy), 32'd0);
      check("flush_hi", hi, 32'h1234);
      check("flush_lo", lo, 32'h5678);
      md_use = 1'b0;

      run_op("mult_req", 3'd1, 32'hFFFFFFFD, 32'd5, MC, 32'hFFFFFFFF, 32'hFFFFFFF1, -1, 2);

      // asynchronous reset in the fourth busy cycle of a divide
      start = 1'b1; op = 3'd4; rs_data = 32'd100; rt_data = 32'd7;
      @(posedge clk); #1;
      start = 1'b0; op = 3'd0;
      check("rst_mid_busy_pre", 32'(busy), 32'd1);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_hi", hi, 32'd0);
      check("rst_mid_lo", lo, 32'd0);
      #3 reset = 1'b1;
      repeat (DC + 2) begin
         @(posedge clk); #1;
         check("rst_after_busy", 32'(busy), 32'd0);
         check("rst_after_lo", lo, 32'd0);
      end
      check("rst_after_hi", hi, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
